// File: rtl/unpool_pkg.sv
// Shared state type and counter sizing helper for the nearest-neighbour unpooling stage.
package unpool_pkg;

   typedef enum logic {
      LOAD,
      REPLAY
   } state_t;

   // Bits needed for a counter spanning 0..max_val, never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/unpool_upsampler_row_line_buffer.sv
// One pooled row of pixels, kept so the row can be replayed for the remaining vertical copies.
// Registered write port, combinational read port.
module row_line_buffer
   import unpool_pkg::*;
#(
   parameter  int bitwidth    = 8,
   parameter  int pooledWidth = 3,
   localparam int IW          = cnt_width(pooledWidth - 1)
) (
   input  logic                clock,
   input  logic                wr_en,
   input  logic [IW-1:0]       wr_idx,
   input  logic [bitwidth-1:0] wr_data,
   input  logic [IW-1:0]       rd_idx,
   output logic [bitwidth-1:0] rd_data
);

   logic [bitwidth-1:0] mem [pooledWidth];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/unpool_upsampler.sv
// Nearest-neighbour unpooling: each pooled pixel becomes a filterWidth x filterWidth block.
// First copy appears one cycle after accept; ready_out stalls the source during copies and row replay.
module unpool_upsampler
   import unpool_pkg::*;
#(
   parameter int bitwidth     = 8,
   parameter int filterWidth  = 3,
   parameter int pooledWidth  = 3,
   parameter int pooledHeight = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [bitwidth-1:0] data_in,
   input  logic                isValid,
   output logic                ready_out,
   output logic [bitwidth-1:0] data_out,
   output logic                valid_out,
   output logic                frameDone_out
);

   localparam int HW = cnt_width(filterWidth);
   localparam int CW = cnt_width(pooledWidth);
   localparam int VW = cnt_width(filterWidth - 1);
   localparam int RW = cnt_width(pooledHeight - 1);
   localparam int IW = cnt_width(pooledWidth - 1);

   localparam logic [HW-1:0] FW_H  = HW'(filterWidth);
   localparam logic [HW-1:0] FW_M1 = HW'(filterWidth - 1);
   localparam logic [CW-1:0] PW_C  = CW'(pooledWidth);
   localparam logic [CW-1:0] PW_M1 = CW'(pooledWidth - 1);
   localparam logic [VW-1:0] FW_V  = VW'(filterWidth - 1);
   localparam logic [RW-1:0] PH_M1 = RW'(pooledHeight - 1);

   state_t              state, state_n;
   logic [HW-1:0]       h_cnt, h_n;
   logic [CW-1:0]       col_cnt, col_n;
   logic [VW-1:0]       v_rep, vrep_n;
   logic [RW-1:0]       row_cnt, row_n;
   logic [bitwidth-1:0] dout_n;
   logic                vld_n;
   logic                fd_n;
   logic                accept;
   logic                row_last;
   logic                wr_en;
   logic [IW-1:0]       rd_idx;
   logic [bitwidth-1:0] rd_data;

   assign ready_out = (state == LOAD) && (col_cnt < PW_C) && (h_cnt == '0 || h_cnt == FW_H);
   assign accept    = isValid && ready_out;
   assign row_last  = (row_cnt == PH_M1);

   row_line_buffer #(
      .bitwidth    (bitwidth),
      .pooledWidth (pooledWidth)
   ) u_row_buf (
      .clock   (clock),
      .wr_en   (wr_en),
      .wr_idx  (col_cnt[IW-1:0]),
      .wr_data (data_in),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= LOAD;
         h_cnt         <= '0;
         col_cnt       <= '0;
         v_rep         <= '0;
         row_cnt       <= '0;
         data_out      <= '0;
         valid_out     <= 1'b0;
         frameDone_out <= 1'b0;
      end else begin
         state         <= state_n;
         h_cnt         <= h_n;
         col_cnt       <= col_n;
         v_rep         <= vrep_n;
         row_cnt       <= row_n;
         data_out      <= dout_n;
         valid_out     <= vld_n;
         frameDone_out <= fd_n;
      end
   end

   always_comb begin
      state_n = state;
      h_n     = h_cnt;
      col_n   = col_cnt;
      vrep_n  = v_rep;
      row_n   = row_cnt;
      dout_n  = data_out;
      vld_n   = valid_out;
      fd_n    = 1'b0;
      wr_en   = 1'b0;
      rd_idx  = '0;

      case (state)
         LOAD: begin
            if (accept) begin
               wr_en  = 1'b1;
               dout_n = data_in;
               vld_n  = 1'b1;
               h_n    = HW'(1);
               col_n  = col_cnt + 1'b1;
               // With no vertical replay the row ends on its last accept, keeping ready_out high.
               if (filterWidth == 1 && col_cnt == PW_M1) begin
                  col_n = '0;
                  row_n = row_last ? '0 : row_cnt + 1'b1;
                  fd_n  = row_last;
               end
            end else if (h_cnt != '0 && h_cnt != FW_H) begin
               h_n = h_cnt + 1'b1;
            end else if (h_cnt == FW_H) begin
               if (col_cnt == PW_C) begin
                  state_n = REPLAY;
                  vrep_n  = VW'(1);
                  col_n   = '0;
                  h_n     = '0;
                  dout_n  = rd_data;
                  vld_n   = 1'b1;
               end else begin
                  vld_n = 1'b0;
                  h_n   = '0;
               end
            end
         end

         REPLAY: begin
            // h_cnt counts copies of the current column shown before the one on data_out.
            if (h_cnt != FW_M1) begin
               h_n  = h_cnt + 1'b1;
               fd_n = row_last && (v_rep == FW_V) && (col_cnt == PW_M1) &&
                      ((h_cnt + 1'b1) == FW_M1);
            end else if (col_cnt != PW_M1) begin
               col_n  = col_cnt + 1'b1;
               h_n    = '0;
               rd_idx = IW'(col_cnt + 1'b1);
               dout_n = rd_data;
            end else if (v_rep != FW_V) begin
               vrep_n = v_rep + 1'b1;
               col_n  = '0;
               h_n    = '0;
               dout_n = rd_data;
            end else begin
               state_n = LOAD;
               col_n   = '0;
               h_n     = '0;
               vrep_n  = '0;
               vld_n   = 1'b0;
               row_n   = row_last ? '0 : row_cnt + 1'b1;
            end
         end

         default: state_n = LOAD;
      endcase
   end

endmodule

// File: tb/tb_unpool_upsampler.sv
// Directed bench for unpool_upsampler across four parameterisations, with a per-instance scoreboard.
module tb_unpool_upsampler;

   logic       clk;
   logic       rst;
   logic [7:0] din;
   logic [3:0] vin;
   logic [3:0] rdy;
   logic [3:0] vo;
   logic [3:0] fd;
   logic [7:0] dout [4];

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [9:0] exp_q [4][$];
   int vcnt [4];
   int run [4];
   int fdcnt [4];
   int fd_idx [4];
   int fd_run [4];
   int rdy_low2 = 0;
   string nm [4] = '{"u0", "u1", "u2", "u3"};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   unpool_upsampler #(.bitwidth(8), .filterWidth(3), .pooledWidth(3), .pooledHeight(1)) u0 (
      .clock(clk), .reset(rst), .data_in(din), .isValid(vin[0]), .ready_out(rdy[0]),
      .data_out(dout[0]), .valid_out(vo[0]), .frameDone_out(fd[0]));
   unpool_upsampler #(.bitwidth(8), .filterWidth(3), .pooledWidth(3), .pooledHeight(2)) u1 (
      .clock(clk), .reset(rst), .data_in(din), .isValid(vin[1]), .ready_out(rdy[1]),
      .data_out(dout[1]), .valid_out(vo[1]), .frameDone_out(fd[1]));
   unpool_upsampler #(.bitwidth(8), .filterWidth(1), .pooledWidth(3), .pooledHeight(2)) u2 (
      .clock(clk), .reset(rst), .data_in(din), .isValid(vin[2]), .ready_out(rdy[2]),
      .data_out(dout[2]), .valid_out(vo[2]), .frameDone_out(fd[2]));
   unpool_upsampler #(.bitwidth(8), .filterWidth(2), .pooledWidth(2), .pooledHeight(2)) u3 (
      .clock(clk), .reset(rst), .data_in(din), .isValid(vin[3]), .ready_out(rdy[3]),
      .data_out(dout[3]), .valid_out(vo[3]), .frameDone_out(fd[3]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one cycle, then sample every instance and score any valid output.
   task automatic tick();
      logic [9:0] e;
      @(posedge clk);
      cyc++;
      #1;
      if (!rst && !rdy[2]) rdy_low2++;
      for (int i = 0; i < 4; i++) begin
         if (vo[i] === 1'b1) begin
            vcnt[i]++;
            run[i]++;
            e = (exp_q[i].size() != 0) ? exp_q[i].pop_front() : 10'h3ff;
            check({nm[i], "_pixel"}, {22'd0, 1'b0, fd[i], dout[i]}, {22'd0, e});
            if (fd[i] === 1'b1) begin
               fdcnt[i]++;
               fd_idx[i] = vcnt[i];
               fd_run[i] = run[i];
            end
         end else begin
            run[i] = 0;
            if (fd[i] === 1'b1) check({nm[i], "_fd_without_valid"}, {31'd0, vo[i]}, 1);
         end
      end
   endtask

   // Expected output of one pooled row: fw output rows, each column repeated fw times.
   task automatic push_row(input int id, input int fw, input int pw, input bit last,
                           input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
      logic [7:0] px [3];
      logic       lp;
      px[0] = p0;
      px[1] = p1;
      px[2] = p2;
      for (int r = 0; r < fw; r++)
         for (int c = 0; c < pw; c++)
            for (int k = 0; k < fw; k++) begin
               lp = last && (r == fw - 1) && (c == pw - 1) && (k == fw - 1);
               exp_q[id].push_back({1'b0, lp, px[c]});
            end
   endtask

   // Present one value and hold it until accepted; acc is the cycle of the accepting edge.
   task automatic send(input int id, input logic [7:0] v, output int acc);
      int n = 0;
      din     = v;
      vin[id] = 1'b1;
      while (!rdy[id] && n < 300) begin
         tick();
         n++;
      end
      check({nm[id], "_accept_timeout"}, {31'd0, rdy[id]}, 1);
      acc = cyc;
      tick();
      vin[id] = 1'b0;
   endtask

   task automatic drain(input int id);
      int n = 0;
      while (exp_q[id].size() != 0 && n < 400) begin
         tick();
         n++;
      end
      check({nm[id], "_drain"}, exp_q[id].size(), 0);
      tick();
      tick();
   endtask

   initial begin
      int a0, a1, a2, a3, ax;
      int v0, f0, bad, low, run27;

      for (int i = 0; i < 4; i++) begin
         vcnt[i] = 0; run[i] = 0; fdcnt[i] = 0; fd_idx[i] = 0; fd_run[i] = 0;
      end
      rst = 1'b1;
      vin = '0;
      din = '0;
      repeat (3) tick();
      rst = 1'b0;

      for (int i = 0; i < 4; i += 2) begin
         check({nm[i], "_reset_valid"}, {31'd0, vo[i]}, 0);
         check({nm[i], "_reset_data"}, {24'd0, dout[i]}, 0);
         check({nm[i], "_reset_fd"}, {31'd0, fd[i]}, 0);
         check({nm[i], "_reset_ready"}, {31'd0, rdy[i]}, 1);
      end

      // Back-to-back row 5,7,9 with a single-row frame.
      push_row(0, 3, 3, 1, 8'd5, 8'd7, 8'd9);
      v0 = vcnt[0]; f0 = fdcnt[0];
      send(0, 8'd5, a0);
      check("t1_first_valid", {31'd0, vo[0]}, 1);
      check("t1_first_data", {24'd0, dout[0]}, 5);
      send(0, 8'd7, a1);
      send(0, 8'd9, a2);
      check("t1_accept_1", a1 - a0, 3);
      check("t1_accept_2", a2 - a0, 6);
      bad = 0; run27 = 0;
      while (cyc - a0 < 28) begin
         if (cyc - a0 >= 9 && rdy[0]) bad++;
         if (cyc - a0 == 27) run27 = run[0];
         tick();
      end
      check("t1_ready_low_replay", bad, 0);
      check("t1_ready_after", {31'd0, rdy[0]}, 1);
      check("t1_valid_after", {31'd0, vo[0]}, 0);
      check("t1_contiguous", run27, 27);
      check("t1_count", vcnt[0] - v0, 27);
      check("t1_fd_count", fdcnt[0] - f0, 1);
      check("t1_fd_index", fd_idx[0] - v0, 27);
      drain(0);

      // Input gap after the first pixel.
      push_row(0, 3, 3, 1, 8'd5, 8'd7, 8'd9);
      v0 = vcnt[0];
      send(0, 8'd5, a0);
      low = 0;
      repeat (5) begin
         tick();
         if (!vo[0]) low++;
      end
      check("t2_bubble", low, 3);
      send(0, 8'd7, a1);
      send(0, 8'd9, a2);
      drain(0);
      check("t2_count", vcnt[0] - v0, 27);
      check("t2_run_at_fd", fd_run[0], 24);

      // Next value waiting throughout the replay.
      push_row(0, 3, 3, 1, 8'd5, 8'd7, 8'd9);
      push_row(0, 3, 3, 1, 8'd11, 8'd12, 8'd13);
      v0 = vcnt[0];
      send(0, 8'd5, a0);
      send(0, 8'd7, a1);
      send(0, 8'd9, a2);
      send(0, 8'd11, a3);
      check("t3_accept_after_replay", a3 - a0, 28);
      check("t3_first_copy_valid", {31'd0, vo[0]}, 1);
      check("t3_first_copy_data", {24'd0, dout[0]}, 11);
      send(0, 8'd12, ax);
      send(0, 8'd13, ax);
      drain(0);
      check("t3_count", vcnt[0] - v0, 54);

      // Two-row frame, then a third row starting a new frame.
      push_row(1, 3, 3, 0, 8'd1, 8'd2, 8'd3);
      push_row(1, 3, 3, 1, 8'd4, 8'd5, 8'd6);
      v0 = vcnt[1]; f0 = fdcnt[1];
      for (int k = 1; k <= 6; k++) send(1, 8'(k), ax);
      drain(1);
      check("t4_count", vcnt[1] - v0, 54);
      check("t4_fd_count", fdcnt[1] - f0, 1);
      check("t4_fd_index", fd_idx[1] - v0, 54);
      push_row(1, 3, 3, 0, 8'd7, 8'd8, 8'd9);
      f0 = fdcnt[1];
      for (int k = 7; k <= 9; k++) send(1, 8'(k), ax);
      drain(1);
      check("t4_new_frame_no_fd", fdcnt[1] - f0, 0);

      // Reset in the middle of a replay abandons the frame.
      push_row(1, 3, 3, 1, 8'd1, 8'd2, 8'd3);
      for (int k = 1; k <= 3; k++) send(1, 8'(k), ax);
      repeat (5) tick();
      check("t5_in_replay", {31'd0, vo[1]}, 1);
      rst = 1'b1;
      exp_q[1].delete();
      tick();
      rst = 1'b0;
      check("t5_valid_cleared", {31'd0, vo[1]}, 0);
      check("t5_ready", {31'd0, rdy[1]}, 1);
      check("t5_fd_cleared", {31'd0, fd[1]}, 0);
      push_row(1, 3, 3, 0, 8'd8, 8'd8, 8'd8);
      v0 = vcnt[1]; f0 = fdcnt[1];
      for (int k = 0; k < 3; k++) send(1, 8'd8, ax);
      drain(1);
      check("t5_count", vcnt[1] - v0, 27);
      check("t5_row0_no_fd", fdcnt[1] - f0, 0);
      push_row(1, 3, 3, 1, 8'd9, 8'd9, 8'd9);
      for (int k = 0; k < 3; k++) send(1, 8'd9, ax);
      drain(1);
      check("t5_row1_fd", fdcnt[1] - f0, 1);

      // filterWidth=1: pass-through.
      push_row(2, 1, 3, 0, 8'd21, 8'd22, 8'd23);
      push_row(2, 1, 3, 1, 8'd24, 8'd25, 8'd26);
      v0 = vcnt[2]; f0 = fdcnt[2];
      send(2, 8'd21, a0);
      check("t6_latency_valid", {31'd0, vo[2]}, 1);
      check("t6_latency_data", {24'd0, dout[2]}, 21);
      for (int k = 22; k <= 26; k++) send(2, 8'(k), a1);
      check("t6_rate", a1 - a0, 5);
      drain(2);
      check("t6_count", vcnt[2] - v0, 6);
      check("t6_fd_index", fd_idx[2] - v0, 6);
      check("t6_fd_count", fdcnt[2] - f0, 1);
      check("t6_ready_always", rdy_low2, 0);

      // filterWidth=2: 2x2 blocks.
      push_row(3, 2, 2, 0, 8'd31, 8'd32, 8'd0);
      push_row(3, 2, 2, 1, 8'd33, 8'd34, 8'd0);
      v0 = vcnt[3]; f0 = fdcnt[3];
      for (int k = 31; k <= 34; k++) send(3, 8'(k), ax);
      drain(3);
      check("t7_count", vcnt[3] - v0, 16);
      check("t7_fd_index", fd_idx[3] - v0, 16);
      check("t7_fd_count", fdcnt[3] - f0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/unpool_upsampler.md
Name: unpool_upsampler

Overview:
- Nearest-neighbour unpooling stage, the inverse of the max-pool stage.
- Consumes a raster stream of pooled values and expands each value into a filterWidth x filterWidth block.
- Emits the full-resolution raster one pixel per cycle with a valid strobe.
- Sits downstream of pooling in decoder/reconstruction paths and feeds stream-consuming stages that use an isValid enable.

Parameters:
- bitwidth, 8, pixel width in bits.
- filterWidth, 3, expansion factor per axis (>=1).
- pooledWidth, 3, pooled pixels per input row (>=1).
- pooledHeight, 3, pooled rows per frame (>=1).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  bitwidth  pooled pixel.
- isValid  input  1  data_in valid; source holds data_in/isValid until accepted.
- ready_out  output  1  data_in accepted on an edge where isValid && ready_out.
- data_out  output  bitwidth  upsampled pixel.
- valid_out  output  1  data_out valid this cycle (no backpressure).
- frameDone_out  output  1  one-cycle pulse coincident with the last valid pixel of a frame.

Behaviour:
- Reset: state=LOAD, all counters 0, valid_out=0, data_out=0, frameDone_out=0. Row buffer contents are don't-care. Reset mid-row or mid-REPLAY abandons the frame; the next accepted pixel is treated as row 0, column 0.
- Registers:
  - hCnt, 0..filterWidth: copies of the current pixel already emitted.
  - colCnt, 0..pooledWidth.
  - vRep, 0..filterWidth-1.
  - rowCnt, 0..pooledHeight-1.
  - rowBuf, pooledWidth x bitwidth.
- ready_out is combinational from registers: state==LOAD && colCnt<pooledWidth && (hCnt==0 || hCnt==filterWidth).
- LOAD, accept edge (cycle t):
  - rowBuf[colCnt]<=data_in, data_out<=data_in, valid_out<=1, hCnt<=1, colCnt++.
  - Output copies appear on cycles t+1..t+filterWidth. Latency is 1 cycle.
- LOAD, 0<hCnt<filterWidth: hold data_out, valid_out=1, hCnt++.
- LOAD, hCnt==filterWidth with no accept and colCnt<pooledWidth: valid_out<=0, hCnt<=0 (bubble until the next input).
- Back-to-back accepts give a gapless output at 1 input per filterWidth cycles.
- LOAD, hCnt==filterWidth and colCnt==pooledWidth:
  - If filterWidth>1: go to REPLAY with vRep<=1, colCnt<=0, hCnt<=0. rowBuf[0] is driven on the next cycle, so there is no gap.
  - If filterWidth==1: row complete; apply the end-of-row rule.
- REPLAY: ready_out=0.
  - Emit rowBuf[colCnt] for filterWidth consecutive cycles per column, for columns 0..pooledWidth-1.
  - After each full row, vRep++.
  - When vRep==filterWidth-1 and its row is complete, apply the end-of-row rule.
  - Output is contiguous throughout REPLAY.
- End-of-row: state<=LOAD, colCnt<=0, hCnt<=0, valid_out<=0 after the last pixel. rowCnt++, wrapping to 0 after pooledHeight-1.
- frameDone_out=1 exactly on the cycle carrying the last pixel of row rowCnt==pooledHeight-1, vRep==filterWidth-1 (or the LOAD row when filterWidth==1).
- Output counts:
  - Per pooled row: filterWidth*filterWidth*pooledWidth pixels.
  - Per frame: pooledWidth*pooledHeight*filterWidth^2 pixels.
- isValid high while ready_out==0 (mid-copy or REPLAY): no effect. The value is taken once ready_out rises, with no loss and no duplication.
- No arithmetic on data; values are passed bit-exact.

Decomposition:
- Package unpool_pkg:
  - state enum {LOAD, REPLAY}.
  - Counter width constants derived with $clog2(filterWidth+1), $clog2(pooledWidth+1), $clog2(pooledHeight).
- Sub-module row_line_buffer, parameterised on bitwidth and pooledWidth:
  - Register array with a write port (wr_en, wr_idx, wr_data).
  - Combinational read port (rd_idx -> rd_data).
- Control FSM and counters stay in unpool_upsampler.

Test Plan:
- Defaults with pooledHeight=1: hold isValid high with 5,7,9. Required:
  - Accepts on cycles 0, 3, 6.
  - data_out 5,5,5,7,7,7,9,9,9 on cycles 1-9, then twice more on cycles 10-27, 27 contiguous valid cycles.
  - ready_out=0 during cycles 9-27.
  - frameDone_out=1 only on cycle 27.
- Input gaps: present 5, idle 4 cycles, then 7, 9. Required: after the first 5,5,5, valid_out drops to 0 until 7 is accepted; REPLAY rows stay gap-free and the pixel order is unchanged.
- isValid held high with 11 during REPLAY. Required: no acceptance until REPLAY ends; 11 is then accepted exactly once, and its first copy appears 1 cycle after ready_out rises.
- pooledHeight=2, two rows (1,2,3 and 4,5,6). Required:
  - 54 valid outputs.
  - frameDone_out only on output 54.
  - A third row is accepted as row 0 of a new frame.
- Reset asserted mid-REPLAY. Required:
  - valid_out=0 on the next cycle.
  - ready_out=1.
  - A fresh row 8,8,8 produces the full 27-pixel block with rowCnt restarted.
- filterWidth=1 and filterWidth=2 builds. Required:
  - filterWidth=1: pass-through with 1-cycle latency and ready_out constantly 1.
  - filterWidth=2: each pixel is emitted 2x2 with the correct frameDone_out position.
